pattern_event_counter: RTL and testbench

//  Consumer stage directly downstream of the serial pattern detector: takes its 2-bit

---
 rtl/pattern_event_counter_pkg.sv | 12 +
 rtl/sat_counter.sv | 28 ++
 rtl/pattern_event_counter.sv | 82 ++++++++
 tb/tb_pattern_event_counter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pattern_event_counter_pkg.sv
// Shared definitions for the pattern event counter: FSM state encoding and event bit indices.
package pattern_event_counter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StCount = 1'b1
  } state_e;

  localparam int unsigned Evt101 = 1;
  localparam int unsigned Evt010 = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the value it would take on inc.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic [W-1:0] q_next
);

  always_comb begin
    q_next = q;
    if (inc && (q != {W{1'b1}})) q_next = q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/pattern_event_counter.sv
// Counts "101"/"010" detector events over fixed windows and publishes each window as a
// report through a valid/ready handshake; partial windows are flushed when enable drops.
module pattern_event_counter
  import pattern_event_counter_pkg::*;
#(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LEN_W  = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       evt,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_cnt101,
  output logic [CNT_W-1:0] rpt_cnt010,
  output logic [LEN_W-1:0] rpt_len,
  output logic             rpt_overrun
);

  state_e             state;
  logic [LEN_W-1:0]   win;
  logic [CNT_W-1:0]   cnt_a, cnt_a_next, cnt_b, cnt_b_next;
  logic               count_en, full_snap, part_snap, clear;

  assign count_en  = (state == StCount) && enable;
  assign full_snap = count_en && (win == LEN_W'(WINDOW - 1));
  // A flush covers only cycles already counted; the cycle enable drops is excluded.
  assign part_snap = (state == StCount) && !enable && (win != '0);
  assign clear     = !count_en || full_snap;

  sat_counter #(.W(CNT_W)) u_cnt_101 (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear),
    .inc    (count_en && evt[Evt101]),
    .q      (cnt_a),
    .q_next (cnt_a_next)
  );

  sat_counter #(.W(CNT_W)) u_cnt_010 (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (clear),
    .inc    (count_en && evt[Evt010]),
    .q      (cnt_b),
    .q_next (cnt_b_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      win         <= '0;
      rpt_valid   <= 1'b0;
      rpt_cnt101  <= '0;
      rpt_cnt010  <= '0;
      rpt_len     <= '0;
      rpt_overrun <= 1'b0;
    end else begin
      case (state)
        StIdle:  if (enable) state <= StCount;
        StCount: if (!enable) state <= StIdle;
        default: state <= StIdle;
      endcase

      if (count_en && !full_snap) win <= win + 1'b1;
      else                        win <= '0;

      if (full_snap || part_snap) begin
        rpt_valid   <= 1'b1;
        rpt_cnt101  <= full_snap ? cnt_a_next : cnt_a;
        rpt_cnt010  <= full_snap ? cnt_b_next : cnt_b;
        rpt_len     <= full_snap ? LEN_W'(WINDOW) : win;
        rpt_overrun <= rpt_valid && !rpt_ready;
      end else if (rpt_valid && rpt_ready) begin
        rpt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pattern_event_counter.sv
// Directed bench for pattern_event_counter: a WINDOW=4 instance and a saturating CNT_W=2 one.
module tb_pattern_event_counter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable, rpt_ready;
  logic [1:0] evt;
  logic       rpt_valid, rpt_overrun;
  logic [7:0] rpt_cnt101, rpt_cnt010;
  logic [2:0] rpt_len;

  logic       en_b, ready_b;
  logic [1:0] evt_b;
  logic       valid_b, overrun_b;
  logic [1:0] cnt101_b, cnt010_b;
  logic [3:0] len_b;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  pattern_event_counter #(.WINDOW(4), .CNT_W(8), .LEN_W(3)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .evt        (evt),
    .rpt_ready  (rpt_ready),
    .rpt_valid  (rpt_valid),
    .rpt_cnt101 (rpt_cnt101),
    .rpt_cnt010 (rpt_cnt010),
    .rpt_len    (rpt_len),
    .rpt_overrun(rpt_overrun)
  );

  pattern_event_counter #(.WINDOW(8), .CNT_W(2), .LEN_W(4)) dut_sat (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (en_b),
    .evt        (evt_b),
    .rpt_ready  (ready_b),
    .rpt_valid  (valid_b),
    .rpt_cnt101 (cnt101_b),
    .rpt_cnt010 (cnt010_b),
    .rpt_len    (len_b),
    .rpt_overrun(overrun_b)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_rpt(input string tag, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [2:0] l, input logic o);
    chk({tag, ".valid"}, 32'(rpt_valid), 32'(v));
    chk({tag, ".cnt101"}, 32'(rpt_cnt101), 32'(a));
    chk({tag, ".cnt010"}, 32'(rpt_cnt010), 32'(b));
    chk({tag, ".len"}, 32'(rpt_len), 32'(l));
    chk({tag, ".overrun"}, 32'(rpt_overrun), 32'(o));
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; evt = 2'b00; rpt_ready = 1'b0;
    en_b = 1'b0; evt_b = 2'b00; ready_b = 1'b0;
    #12;
    chk_rpt("reset", 1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    reset_n = 1'b1;

    // Full window: enable cycle not counted, then 10,00,01,10.
    rpt_ready = 1'b1; enable = 1'b1; evt = 2'b00; tick();
    evt = 2'b10; tick();
    evt = 2'b00; tick();
    evt = 2'b01; tick();
    chk("full.pre_valid", 32'(rpt_valid), 32'd0);
    evt = 2'b10; tick();
    chk_rpt("full", 1'b1, 8'd2, 8'd1, 3'd4, 1'b0);
    enable = 1'b0; evt = 2'b00; tick();
    chk_rpt("full.accepted", 1'b0, 8'd2, 8'd1, 3'd4, 1'b0);

    // Back-to-back windows without ready: second report flags overrun.
    rpt_ready = 1'b0; enable = 1'b1; evt = 2'b10; tick();
    repeat (4) tick();
    chk_rpt("b2b.first", 1'b1, 8'd4, 8'd0, 3'd4, 1'b0);
    repeat (4) tick();
    chk_rpt("b2b.second", 1'b1, 8'd4, 8'd0, 3'd4, 1'b1);
    enable = 1'b0; evt = 2'b00; rpt_ready = 1'b1; tick();
    chk_rpt("b2b.accepted", 1'b0, 8'd4, 8'd0, 3'd4, 1'b1);

    // Flush after three counted cycles of evt=01; the drop cycle's event is excluded.
    enable = 1'b1; evt = 2'b00; tick();
    evt = 2'b01; repeat (3) tick();
    chk("flush.pre_valid", 32'(rpt_valid), 32'd0);
    enable = 1'b0; tick();
    chk_rpt("flush", 1'b1, 8'd0, 8'd3, 3'd3, 1'b0);
    evt = 2'b00; tick();
    chk("flush.accepted", 32'(rpt_valid), 32'd0);
    enable = 1'b1; tick();
    enable = 1'b0; evt = 2'b11; tick();
    chk("flush.win0_none", 32'(rpt_valid), 32'd0);
    tick();
    chk("idle.ignores_evt", 32'(rpt_valid), 32'd0);

    // Accept and snapshot on the same edge; evt=11 counts into both counters.
    rpt_ready = 1'b0; enable = 1'b1; evt = 2'b00; tick();
    evt = 2'b11; repeat (4) tick();
    chk_rpt("same.win1", 1'b1, 8'd4, 8'd4, 3'd4, 1'b0);
    evt = 2'b10; tick(); tick();
    evt = 2'b00; tick();
    chk_rpt("same.stable", 1'b1, 8'd4, 8'd4, 3'd4, 1'b0);
    rpt_ready = 1'b1; evt = 2'b01; tick();
    chk_rpt("same.win2", 1'b1, 8'd2, 8'd1, 3'd4, 1'b0);
    enable = 1'b0; evt = 2'b00; tick();
    chk("same.accepted", 32'(rpt_valid), 32'd0);

    // Asynchronous reset mid-window with a pending report.
    rpt_ready = 1'b0; enable = 1'b1; evt = 2'b10; tick();
    repeat (4) tick();
    chk("rst.pending", 32'(rpt_valid), 32'd1);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    chk_rpt("rst.async", 1'b0, 8'd0, 8'd0, 3'd0, 1'b0);
    enable = 1'b0; #2; reset_n = 1'b1; tick();
    chk("rst.after", 32'(rpt_valid), 32'd0);
    enable = 1'b1; tick();
    repeat (3) tick();
    chk("rst.fresh_pre", 32'(rpt_valid), 32'd0);
    tick();
    chk_rpt("rst.fresh", 1'b1, 8'd4, 8'd0, 3'd4, 1'b0);
    enable = 1'b0; evt = 2'b00; rpt_ready = 1'b1; tick();

    // Saturation: CNT_W=2, WINDOW=8, evt=10 every cycle.
    ready_b = 1'b1; en_b = 1'b1; evt_b = 2'b10; tick();
    repeat (7) tick();
    chk("sat.pre_valid", 32'(valid_b), 32'd0);
    tick();
    chk("sat.valid", 32'(valid_b), 32'd1);
    chk("sat.cnt101", 32'(cnt101_b), 32'd3);
    chk("sat.cnt010", 32'(cnt010_b), 32'd0);
    chk("sat.len", 32'(len_b), 32'd8);
    chk("sat.overrun", 32'(overrun_b), 32'd0);
    en_b = 1'b0; tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
